// File: rtl/mips_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pipe
//   Control-word pipeline for a classic 5-stage MIPS core.  Decodes the
//   ID-stage opcode into a 9-bit control word and carries it, together with a
//   valid bit, through STAGES registered stages (EX, MEM, WB, ...).  Detects
//   the load-use hazard between the instruction in EX and the one in ID,
//   flags unknown opcodes, and counts instructions retiring from the last
//   stage.
//
// Parameters
//   STAGES : number of control-word stages after decode (2..8), stage 0 = EX
//   CNTW   : width of the retired-instruction counter
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   op_i        : ID-stage opcode
//   id_valid_i  : ID stage holds a real instruction
//   id_rs_i     : ID-stage rs register number
//   id_rt_i     : ID-stage rt register number
//   stall_i     : freeze every stage
//   flush_i     : squash the instruction entering EX
//   cw_pipe_o   : registered control word per stage, stage k at [9k+8:9k]
//   vld_pipe_o  : registered valid bit per stage
//   hazard_o    : combinational load-use stall request to PC/IF/ID
//   illegal_o   : one-cycle pulse when a valid unknown opcode enters EX
//   retired_o   : saturating count of valid instructions leaving the pipe
// -----------------------------------------------------------------------------
module mips_ctrl_pipe #(
   parameter int STAGES = 3,
   parameter int CNTW   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            op_i,
   input  logic                  id_valid_i,
   input  logic [4:0]            id_rs_i,
   input  logic [4:0]            id_rt_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   output logic [STAGES*9-1:0]   cw_pipe_o,
   output logic [STAGES-1:0]     vld_pipe_o,
   output logic                  hazard_o,
   output logic                  illegal_o,
   output logic [CNTW-1:0]       retired_o
);

   // Control word bit positions
   localparam int CW_MEMREAD = 4;

   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   // Decode table: returns {illegal, cw[8:0]}.
   // cw = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
   function automatic logic [9:0] decode_op(input logic [5:0] op);
      logic [9:0] res;
      case (op)
         6'b000000: res = {1'b0, 9'h122};   // R-type
         6'b100011: res = {1'b0, 9'h0F0};   // lw
         6'b101011: res = {1'b0, 9'h088};   // sw
         6'b000100: res = {1'b0, 9'h005};   // beq
         6'b001000: res = {1'b0, 9'h0A0};   // addi
         default:   res = {1'b1, 9'h000};   // unknown: travels as a NOP
      endcase
      return res;
   endfunction

   // Pipeline state
   logic [STAGES-1:0][8:0] cw_q,      cw_d;
   logic [STAGES-1:0]      vld_q,     vld_d;
   logic [4:0]             ex_rt_q,   ex_rt_d;
   logic                   illegal_q, illegal_d;
   logic [CNTW-1:0]        retired_q, retired_d;

   logic [9:0]             dec_s;
   logic                   hazard_s;

   // Decode the ID-stage opcode
   always_comb begin
      dec_s = decode_op(op_i);
   end

   // Load-use hazard: a valid lw in EX whose destination (rt) is read in ID.
   // Register 0 is hard-wired so it never creates a dependency.
   always_comb begin
      hazard_s = 1'b0;
      if (vld_q[0] && cw_q[0][CW_MEMREAD] && id_valid_i && (ex_rt_q != 5'd0) &&
          ((ex_rt_q == id_rs_i) || (ex_rt_q == id_rt_i))) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
   end

   // Next-state: stall holds everything, flush/hazard inserts a bubble in EX,
   // otherwise the decoded word enters EX and older stages shift down.
   always_comb begin
      cw_d      = cw_q;
      vld_d     = vld_q;
      ex_rt_d   = ex_rt_q;
      illegal_d = 1'b0;
      retired_d = retired_q;

      if (stall_i) begin
         cw_d      = cw_q;
         vld_d     = vld_q;
         ex_rt_d   = ex_rt_q;
         illegal_d = 1'b0;
         retired_d = retired_q;
      end else begin
         // Counter saturates instead of wrapping
         if (vld_q[STAGES-1] && (retired_q != CNT_MAX)) begin
            retired_d = retired_q + CNT_ONE;
         end else begin
            retired_d = retired_q;
         end

         for (int k = 1; k < STAGES; k++) begin
            cw_d[k]  = cw_q[k-1];
            vld_d[k] = vld_q[k-1];
         end

         if (flush_i || hazard_s) begin
            cw_d[0]   = 9'h000;
            vld_d[0]  = 1'b0;
            ex_rt_d   = 5'd0;
            illegal_d = 1'b0;
         end else if (id_valid_i) begin
            cw_d[0]   = dec_s[8:0];
            vld_d[0]  = 1'b1;
            ex_rt_d   = id_rt_i;
            illegal_d = dec_s[9];
         end else begin
            cw_d[0]   = 9'h000;
            vld_d[0]  = 1'b0;
            ex_rt_d   = id_rt_i;
            illegal_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cw_q      <= '0;
         vld_q     <= '0;
         ex_rt_q   <= 5'd0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         cw_q      <= cw_d;
         vld_q     <= vld_d;
         ex_rt_q   <= ex_rt_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Output mapping (packed stage array already matches the [9k+8:9k] layout)
   always_comb begin
      cw_pipe_o  = cw_q;
      vld_pipe_o = vld_q;
      hazard_o   = hazard_s;
      illegal_o  = illegal_q;
      retired_o  = retired_q;
   end

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_mips_ctrl_pipe
//   Directed plus randomized stimulus for mips_ctrl_pipe, checked against a
//   behavioural reference kept as plain arrays and a lookup table.  A second
//   instance with a 4-bit counter shares the inputs to exercise saturation.
// -----------------------------------------------------------------------------
module tb_mips_ctrl_pipe;

   localparam int S = 3;

   logic             clk;
   logic             rst;
   logic [5:0]       op_i;
   logic             id_valid_i;
   logic [4:0]       id_rs_i;
   logic [4:0]       id_rt_i;
   logic             stall_i;
   logic             flush_i;
   logic [S*9-1:0]   cw_pipe_o,  cw4;
   logic [S-1:0]     vld_pipe_o, vld4;
   logic             hazard_o,   hazard4;
   logic             illegal_o,  illegal4;
   logic [15:0]      retired_o;
   logic [3:0]       retired4;

   mips_ctrl_pipe #(.STAGES(S), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .op_i(op_i), .id_valid_i(id_valid_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .stall_i(stall_i), .flush_i(flush_i),
      .cw_pipe_o(cw_pipe_o), .vld_pipe_o(vld_pipe_o), .hazard_o(hazard_o),
      .illegal_o(illegal_o), .retired_o(retired_o)
   );

   mips_ctrl_pipe #(.STAGES(S), .CNTW(4)) dut4 (
      .clk(clk), .rst(rst), .op_i(op_i), .id_valid_i(id_valid_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .stall_i(stall_i), .flush_i(flush_i),
      .cw_pipe_o(cw4), .vld_pipe_o(vld4), .hazard_o(hazard4),
      .illegal_o(illegal4), .retired_o(retired4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int misses  = 0;

   // Reference model: an opcode table plus a list of in-flight instructions
   int        lut[bit [5:0]];
   bit [8:0]  m_cw[S];
   bit        m_vld[S];
   bit [4:0]  m_rt;
   bit        m_ill;
   int        m_cnt;
   bit        m_init = 1'b0;
   bit [5:0]  legal_ops[5] = '{6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000000};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         misses++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hazard(input bit v, input bit [4:0] rs, input bit [4:0] rt);
      // a valid load in EX writes m_rt; ID reading it must wait one cycle
      return m_vld[0] && (m_cw[0] == 9'h0F0) && v && (m_rt != 5'd0) &&
             ((m_rt == rs) || (m_rt == rt));
   endfunction

   function automatic logic [S*9-1:0] exp_cw();
      logic [S*9-1:0] r;
      for (int k = 0; k < S; k++) r[9*k +: 9] = m_cw[k];
      return r;
   endfunction

   function automatic logic [S-1:0] exp_vld();
      logic [S-1:0] r;
      for (int k = 0; k < S; k++) r[k] = m_vld[k];
      return r;
   endfunction

   // One clock: drive inputs, check hazard before the edge, advance model, check outputs
   task automatic step(input bit r, input bit st, input bit fl, input bit v,
                       input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt);
      bit hz;
      rst = r; stall_i = st; flush_i = fl; id_valid_i = v;
      op_i = op; id_rs_i = rs; id_rt_i = rt;
      #1;
      hz = m_init ? model_hazard(v, rs, rt) : 1'b0;
      if (m_init && !r) chk("hazard", {63'd0, hazard_o}, {63'd0, hz});
      @(posedge clk);
      #1;
      if (r) begin
         for (int k = 0; k < S; k++) begin m_cw[k] = 9'h000; m_vld[k] = 1'b0; end
         m_rt = 5'd0; m_ill = 1'b0; m_cnt = 0; m_init = 1'b1;
      end else if (st) begin
         m_ill = 1'b0;
      end else begin
         if (m_vld[S-1]) m_cnt++;
         for (int k = S-1; k > 0; k--) begin m_cw[k] = m_cw[k-1]; m_vld[k] = m_vld[k-1]; end
         if (fl || hz) begin
            m_cw[0] = 9'h000; m_vld[0] = 1'b0; m_ill = 1'b0;
         end else begin
            m_vld[0] = v;
            m_cw[0]  = (v && lut.exists(op)) ? 9'(lut[op]) : 9'h000;
            m_ill    = v && !lut.exists(op);
            m_rt     = rt;
         end
      end
      chk("cw_pipe",  64'(cw_pipe_o),  64'(exp_cw()));
      chk("vld_pipe", 64'(vld_pipe_o), 64'(exp_vld()));
      chk("illegal",  {63'd0, illegal_o}, {63'd0, m_ill});
      chk("retired",  64'(retired_o), 64'(m_cnt > 65535 ? 65535 : m_cnt));
      chk("retired4", 64'(retired4),  64'(m_cnt > 15 ? 15 : m_cnt));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 5'd0);
   endtask

   initial begin
      lut[6'b000000] = 9'h122;
      lut[6'b100011] = 9'h0F0;
      lut[6'b101011] = 9'h088;
      lut[6'b000100] = 9'h005;
      lut[6'b001000] = 9'h0A0;

      // reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 5'd0);
      chk("rst_cw",  64'(cw_pipe_o), 64'd0);
      chk("rst_ret", 64'(retired_o), 64'd0);
      chk("rst_haz", {63'd0, hazard_o}, 64'd0);

      // lw, sw, beq, addi, R-type back to back with no dependencies
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b100011, 5'd1, 5'd2);
      chk("seq_lw_ex", 64'(cw_pipe_o[8:0]), 64'h0F0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b101011, 5'd3, 5'd4);
      chk("seq_sw_ex", 64'(cw_pipe_o[8:0]), 64'h088);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b000100, 5'd3, 5'd4);
      chk("seq_lw_wb", 64'(cw_pipe_o[26:18]), 64'h0F0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b001000, 5'd6, 5'd7);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 5'd8, 5'd9);
      chk("seq_r_ex", 64'(cw_pipe_o[8:0]), 64'h122);
      idle(4);
      chk("seq_ret5", 64'(retired_o), 64'd5);

      // load-use hazard, then a load to r0 which never stalls
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b100011, 5'd1, 5'd5);
      rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b1;
      op_i = 6'b000000; id_rs_i = 5'd5; id_rt_i = 5'd9;
      #1;
      chk("haz_on", {63'd0, hazard_o}, 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 5'd5, 5'd9);
      chk("haz_bubble", {63'd0, vld_pipe_o[0]}, 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 5'd5, 5'd9);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b100011, 5'd1, 5'd0);
      rst = 1'b0; id_valid_i = 1'b1; op_i = 6'b000000; id_rs_i = 5'd0; id_rt_i = 5'd0;
      #1;
      chk("haz_r0", {63'd0, hazard_o}, 64'd0);

      // fill, then stall 3 cycles with flush also asserted
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b001000, 5'd2, 5'd3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b101011, 5'd2, 5'd3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b000100, 5'd2, 5'd3);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 6'b000000, 5'd1, 5'd1);
      chk("stall_vld", 64'(vld_pipe_o), 64'h7);
      chk("stall_ex",  64'(cw_pipe_o[8:0]), 64'h005);

      // illegal opcode
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b111111, 5'd0, 5'd0);
      chk("ill_pulse", {63'd0, illegal_o}, 64'd1);
      chk("ill_cw",    64'(cw_pipe_o[8:0]), 64'h000);
      chk("ill_vld",   {63'd0, vld_pipe_o[0]}, 64'd1);
      idle(1);
      chk("ill_once",  {63'd0, illegal_o}, 64'd0);

      // 20 valid instructions: 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 5'd1, 5'd2);
      idle(3);
      chk("sat15", 64'(retired4), 64'd15);

      // reset with full pipe
      step(1'b1, 1'b0, 1'b0, 1'b1, 6'b100011, 5'd1, 5'd2);
      chk("midrst_cw",  64'(cw_pipe_o), 64'd0);
      chk("midrst_vld", 64'(vld_pipe_o), 64'd0);
      chk("midrst_ret", 64'(retired_o), 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 6'b100011, 5'd1, 5'd2);
      chk("refill_ex", 64'(cw_pipe_o[8:0]), 64'h0F0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit [5:0] op;
         int       pick;
         pick = int'($urandom_range(0, 6));
         op   = (pick < 5) ? legal_ops[pick] : 6'($urandom_range(0, 63));
         step(($urandom_range(0, 49) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 4) != 0),
              op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
